// File: rtl/register_reader.sv
// register_reader: tagged valid/ready read responder that samples reg_value after a fixed settle delay
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   reg_value             register output bus being polled
//   req_valid/req_ready   request handshake, req_tag travels with the request
//   rsp_valid/rsp_ready   response handshake carrying rsp_data/rsp_tag/rsp_changed
//   read_count            completed responses, saturating at 0xFFFF
// Optional feature: define REGISTER_READER_CHANGE_DETECT_EN to build the shadow
// register that drives rsp_changed; otherwise rsp_changed is tied to 0.
module register_reader #(
  parameter int WIDTH        = 8,
  parameter int TAG_WIDTH    = 4,
  parameter int SAMPLE_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     reg_value,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic                 rsp_changed,
  output logic [15:0]          read_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [15:0]          count_q, count_d;
  logic                 sample;
  logic                 hs;
  assign req_ready  = state_q == S_IDLE;
  assign rsp_valid  = state_q == S_RESP;
  assign hs         = rsp_valid && rsp_ready;
  assign rsp_data   = data_q;
  assign rsp_tag    = tag_q;
  assign read_count = count_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    count_d = count_q;
    sample  = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        tag_d = req_tag;
        cnt_d = 4'(SAMPLE_DELAY);
        // zero delay samples on the accept edge itself
        sample  = SAMPLE_DELAY == 0;
        state_d = SAMPLE_DELAY == 0 ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        sample  = cnt_q == 4'd1;
        state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
      end
      S_RESP: if (rsp_ready) begin
        count_d = &count_q ? count_q : count_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    data_d = sample ? reg_value : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
`ifdef REGISTER_READER_CHANGE_DETECT_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             chg_q, chg_d;
  // shadow tracks the last value actually delivered, not the last sampled
  assign shadow_d    = hs ? data_q : shadow_q;
  assign chg_d       = sample ? reg_value != shadow_q : chg_q;
  assign rsp_changed = chg_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      chg_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      chg_q    <= chg_d;
    end
  end
`else
  assign rsp_changed = 1'b0;
`endif
endmodule
